// File: rtl/rf_pulse_decoder.sv
// rtl/rf_pulse_decoder.sv - RF gate pulse width/gap measurement, classification and pi/2-pi-pi/2 sequence check
// Sequence checker is compiled in only when RF_PULSE_DECODER_SEQ_CHECK_EN is defined.
module rf_pulse_decoder #(
    parameter int CW          = 20,
    parameter int PI_2_W      = 333,
    parameter int PI_W        = 666,
    parameter int TOL         = 8,
    parameter int GAP_TOL     = 16,
    parameter int GAP_TIMEOUT = 200000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rf_in_i,
    input  logic          clear_i,
    output logic          pulse_valid_o,
    output logic [1:0]    pulse_kind_o,
    output logic [CW-1:0] pulse_width_o,
    output logic [CW-1:0] gap_width_o,
    output logic          seq_done_o,
    output logic          seq_err_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW:0]   PI_2_X  = (CW+1)'(PI_2_W);
    localparam logic [CW:0]   PI_X    = (CW+1)'(PI_W);
    localparam logic [CW:0]   TOL_X   = (CW+1)'(TOL);

    logic          rf_m_q, rf_s_q, rf_d_q;
    logic          rise, fall;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] lo_cnt_q, lo_cnt_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] gap_lat_q, gap_lat_d;
    logic          meas_vld_q, meas_vld_d;
    logic [CW-1:0] meas_w_q, meas_w_d;
    logic [CW-1:0] meas_g_q, meas_g_d;
    logic [1:0]    kind;
    logic          pulse_valid_q, pulse_valid_d;
    logic [1:0]    pulse_kind_q, pulse_kind_d;
    logic [CW-1:0] pulse_width_q, pulse_width_d;
    logic [CW-1:0] gap_width_q, gap_width_d;

    function automatic logic [1:0] classify(input logic [CW-1:0] w);
        logic [CW:0] wx, d2, d1;
        logic [1:0]  k;
        wx = {1'b0, w};
        d2 = (wx >= PI_2_X) ? wx - PI_2_X : PI_2_X - wx;
        d1 = (wx >= PI_X) ? wx - PI_X : PI_X - wx;
        if (w == CNT_MAX)    k = 2'd3;
        else if (d2 <= TOL_X) k = 2'd1;
        else if (d1 <= TOL_X) k = 2'd2;
        else                  k = 2'd0;
        return k;
    endfunction

    // Synchronizer resets high so a gate already high at reset release never looks like a rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_m_q <= 1'b1;
            rf_s_q <= 1'b1;
            rf_d_q <= 1'b1;
        end else begin
            rf_m_q <= rf_in_i;
            rf_s_q <= rf_m_q;
            rf_d_q <= rf_s_q;
        end
    end

    assign rise = rf_s_q & ~rf_d_q;
    assign fall = ~rf_s_q & rf_d_q;
    assign kind = classify(meas_w_q);

    always_comb begin
        hi_cnt_d   = hi_cnt_q;
        lo_cnt_d   = lo_cnt_q;
        armed_d    = armed_q | rise;
        gap_lat_d  = gap_lat_q;
        meas_vld_d = fall & armed_q;
        meas_w_d   = meas_w_q;
        meas_g_d   = meas_g_q;
        if (rise) begin
            hi_cnt_d  = CW'(1);
            gap_lat_d = armed_q ? lo_cnt_q : '0;
        end else if (rf_s_q && hi_cnt_q != CNT_MAX) begin
            hi_cnt_d = hi_cnt_q + CW'(1);
        end
        if (fall) begin
            lo_cnt_d = CW'(1);
            meas_w_d = hi_cnt_q;
            meas_g_d = gap_lat_q;
        end else if (!rf_s_q && lo_cnt_q != CNT_MAX) begin
            lo_cnt_d = lo_cnt_q + CW'(1);
        end
        if (clear_i) begin
            hi_cnt_d   = '0;
            lo_cnt_d   = '0;
            armed_d    = 1'b0;
            gap_lat_d  = '0;
            meas_vld_d = 1'b0;
        end
    end

    // Reported fields hold their last values across a clear; only the strobe is suppressed.
    always_comb begin
        pulse_valid_d = meas_vld_q & ~clear_i;
        pulse_kind_d  = pulse_kind_q;
        pulse_width_d = pulse_width_q;
        gap_width_d   = gap_width_q;
        if (meas_vld_q && !clear_i) begin
            pulse_kind_d  = kind;
            pulse_width_d = meas_w_q;
            gap_width_d   = meas_g_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            armed_q       <= 1'b0;
            gap_lat_q     <= '0;
            meas_vld_q    <= 1'b0;
            meas_w_q      <= '0;
            meas_g_q      <= '0;
            pulse_valid_q <= 1'b0;
            pulse_kind_q  <= 2'd0;
            pulse_width_q <= '0;
            gap_width_q   <= '0;
        end else begin
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            armed_q       <= armed_d;
            gap_lat_q     <= gap_lat_d;
            meas_vld_q    <= meas_vld_d;
            meas_w_q      <= meas_w_d;
            meas_g_q      <= meas_g_d;
            pulse_valid_q <= pulse_valid_d;
            pulse_kind_q  <= pulse_kind_d;
            pulse_width_q <= pulse_width_d;
            gap_width_q   <= gap_width_d;
        end
    end

    assign pulse_valid_o = pulse_valid_q;
    assign pulse_kind_o  = pulse_kind_q;
    assign pulse_width_o = pulse_width_q;
    assign gap_width_o   = gap_width_q;

`ifdef RF_PULSE_DECODER_SEQ_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_GOT_A, S_GOT_B} seq_state_e;

    localparam logic [CW-1:0] TIMEOUT_C = CW'(GAP_TIMEOUT);
    localparam logic [CW:0]   GAP_TOL_X = (CW+1)'(GAP_TOL);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] g1_q, g1_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW:0]   gap_diff;

    assign gap_diff = ({1'b0, meas_g_q} >= {1'b0, g1_q}) ? {1'b0, meas_g_q} - {1'b0, g1_q}
                                                        : {1'b0, g1_q} - {1'b0, meas_g_q};

    always_comb begin
        state_d = state_q;
        g1_d    = g1_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (meas_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    if (kind == 2'd1) state_d = S_GOT_A;
                end
                S_GOT_A: begin
                    if (kind == 2'd2) begin
                        state_d = S_GOT_B;
                        g1_d    = meas_g_q;
                    end else if (kind == 2'd1) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_GOT_B: begin
                    if (kind == 2'd1 && gap_diff <= GAP_TOL_X) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (kind == 2'd1) begin
                        err_d   = 1'b1;
                        state_d = S_GOT_A;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && lo_cnt_q == TIMEOUT_C) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
        if (clear_i) begin
            state_d = S_IDLE;
            g1_d    = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            g1_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g1_q    <= g1_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign seq_done_o = done_q;
    assign seq_err_o  = err_q;
`else
    // Gap limits only matter to the sequence checker; they stay in the parameter list for a uniform instantiation.
    assign seq_done_o = 1'b0;
    assign seq_err_o  = (GAP_TIMEOUT < 0) && (GAP_TOL < 0);
`endif

endmodule

// File: doc/rf_pulse_decoder.md
# rf_pulse_decoder

- Receive-side counterpart to the RF pulse generator.
- Samples the RF gate line driven to the RF controller and measures each high pulse and the low gap before it, in `clk` cycles.
- Classifies each pulse as pi/2, pi or other.
- Checks for a complete Mach-Zehnder pi/2 – pi – pi/2 sequence with matched free-evolution gaps.
- Sits on the loopback/monitor path and feeds the status register block.

## Interface
- `CW`, 20 — width of width/gap counters, saturating.
- `PI_2_W`, 333 — nominal pi/2 width, cycles.
- `PI_W`, 666 — nominal pi width, cycles.
- `TOL`, 8 — ± width tolerance for classification, cycles.
- `GAP_TOL`, 16 — ± allowed mismatch between the two gaps of a sequence, cycles.
- `GAP_TIMEOUT`, 200000 — low time that aborts a partial sequence, cycles.

Ports:
- `clk` input 1 — system clock; all logic on rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `rf_in` input 1 — monitored RF gate, asynchronous to `clk`.
- `clear` input 1 — synchronous flush of counters and sequence state.
- `pulse_valid` output 1 — one-cycle strobe when a pulse has been measured.
- `pulse_kind` output 2 — 0 other, 1 pi/2, 2 pi, 3 width overflow.
- `pulse_width` output CW — high time of last pulse.
- `gap_width` output CW — low time preceding last pulse; 0 if first since arm.
- `seq_done` output 1 — one-cycle strobe on a valid pi/2–pi–pi/2 sequence.
- `seq_err` output 1 — one-cycle strobe on a broken sequence.

## Operation
- **Synchronizer and edges.** `rf_in` passes through a 2-FF synchronizer to `rf_s`. `rf_d` is `rf_s` delayed by one cycle. Rise = `rf_s & ~rf_d`; fall = `~rf_s & rf_d`.
- **Counters.**
  - `hi_cnt` is cleared on rise and increments each cycle `rf_s`=1.
  - `lo_cnt` is cleared on fall and increments each cycle `rf_s`=0.
  - Both saturate at 2^CW−1.
- **Arming.**
  - An `armed` flag sets on the first observed rise after reset or `clear`.
  - A fall while not armed is discarded, so a pulse already in progress at reset release is never reported.
  - The gap reported for the first pulse after arming is 0.
- **Classification on fall.**
  - Width is the `hi_cnt` value including the fall cycle's count, i.e. exactly the synchronized high cycles.
  - kind=3 if saturated; else 1 if |w−PI_2_W|≤TOL; else 2 if |w−PI_W|≤TOL; else 0.
  - Differences are computed at CW+1 bits with no wrap.
- **Sequence FSM** (states IDLE, GOT_A, GOT_B):
  - IDLE: pi/2 → GOT_A. Any other kind stays in IDLE with no error.
  - GOT_A: pi → GOT_B, and the gap is latched as g1. Pi/2 → seq_err, stay in GOT_A (restart). Other → seq_err, IDLE.
  - GOT_B: pi/2 with |gap−g1|≤GAP_TOL → seq_done, IDLE. Pi/2 with a mismatched gap → seq_err, GOT_A. Other → seq_err, IDLE.
  - In GOT_A or GOT_B, `lo_cnt` reaching GAP_TIMEOUT → seq_err once, IDLE.
- **Boundary rules.**
  - `clear` coincident with a fall: `clear` wins. No `pulse_valid`, counters zero, `armed`=0, FSM in IDLE.
  - Reset asserted mid-pulse: all state is dropped immediately.

## Timing
- All outputs reset to 0; FSM resets to IDLE; `armed` resets to 0.
- Latency from the first `clk` edge sampling `rf_in`=0 after a pulse to `pulse_valid` high is 4 cycles: 2 synchronizer cycles, 1 edge detect, 1 output register.
- `pulse_width`, `gap_width` and `pulse_kind` update in the same cycle as `pulse_valid` and hold until the next pulse.
- `seq_done`/`seq_err` assert in the same cycle as the `pulse_valid` that caused them. The timeout `seq_err` asserts one cycle after `lo_cnt` reaches GAP_TIMEOUT.
- `seq_done` and `seq_err` are never high together.
- Minimum resolvable pulse or gap is 1 cycle. Back-to-back events produce one strobe per fall.

## Configuration
- `RF_PULSE_DECODER_SEQ_CHECK_EN`
  - Defined: sequence FSM, g1 register and timeout are compiled in as described.
  - Undefined: FSM and g1 are absent; `seq_done` and `seq_err` are tied to 0. Measurement and classification are unchanged.

## Test plan
- Reset, then `rf_in` high 333 cycles → `pulse_valid` 4 cycles after the fall; kind=1, width=333, gap=0.
- Pulses 333 high / 33333 low / 666 high / 33333 low / 333 high → kinds 1, 2, 1; gaps 33333 both; `seq_done` once, `seq_err` never.
- Same sequence with the second gap 33400 → `seq_err` on the third pulse, FSM in GOT_A.
- Pi/2, then `rf_in` low for 200000 cycles → one `seq_err` at the timeout; a following 666-cycle pulse gives kind=2 with no error.
- `rf_in` high across `rst_n` release, falls 50 cycles later → no `pulse_valid`. Then a 340-cycle pulse → kind=1; then a 700-cycle pulse → kind=0.
- `rf_in` high for 2^20+5 cycles → kind=3, width=0xFFFFF. `clear` on the fall cycle of another pulse → no strobe, outputs hold their last values.
